// File: rtl/fp_mul_seq.sv
// Iterative IEEE-754 binary32 multiplier (shift-add mantissa multiply, BITS_PER_CYCLE bits per step).
// Latency: done after edge 3 + 24/BITS_PER_CYCLE from the start-sampling edge; specials after edge 2.
// Backpressure: start is only honoured in IDLE; busy stays high until the edge leaving DONE.
// Optional build macro FP_MUL_RNE_EN: round-to-nearest-even in NORM instead of truncation.
module fp_mul_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam int NCYC = 24 / BITS_PER_CYCLE;
  localparam int CW   = 5;
  localparam int PW   = 24 + BITS_PER_CYCLE;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        mcand_q, mcand_d;
  logic [23:0]        mplier_q, mplier_d;
  logic [47:0]        prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  // ---------------------------------------------------------------
  // Operand classification of the latched inputs (used in UNPACK)
  // ---------------------------------------------------------------
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        op_sign;
  logic        is_special;
  logic [31:0] special_res;

  assign ea      = a_q[30:23];
  assign eb      = b_q[30:23];
  assign fa      = a_q[22:0];
  assign fb      = b_q[22:0];
  assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
  // Denormals are flushed: any zero exponent field counts as zero.
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign op_sign = a_q[31] ^ b_q[31];

  // Special-case result selection, priority NaN > inf > zero
  always_comb begin
    is_special  = 1'b1;
    special_res = 32'h0000_0000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      special_res = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      special_res = {op_sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      special_res = {op_sign, 31'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // ---------------------------------------------------------------
  // One shift-add step. The upper half of the product accumulates
  // mcand * chunk, then the whole register shifts right by the chunk
  // width, so after NCYC steps it holds the exact 48-bit product.
  // The partial sum always fits PW bits because the running product
  // stays below mcand * 2^24.
  // ---------------------------------------------------------------
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [PW-1:0]             partial;
  logic [47:0]               prod_step;

  assign chunk     = mplier_q[BITS_PER_CYCLE-1:0];
  assign partial   = PW'(prod_q[47:24]) + PW'(mcand_q) * PW'(chunk);
  assign prod_step = 48'({partial, prod_q[23:0]} >> BITS_PER_CYCLE);

  // ---------------------------------------------------------------
  // Normalisation and rounding of the finished product
  // ---------------------------------------------------------------
  logic              p_hi;
  logic [22:0]       frac_t, frac_r;
  logic signed [9:0] exp_t, exp_r;

  assign p_hi   = prod_q[47];
  assign frac_t = p_hi ? prod_q[46:24] : prod_q[45:23];
  assign exp_t  = p_hi ? (exp_q + 10'sd1) : exp_q;

`ifdef FP_MUL_RNE_EN
  logic        guard_bit, sticky_bit, round_up;
  logic [23:0] frac_inc;

  assign guard_bit  = p_hi ? prod_q[23] : prod_q[22];
  assign sticky_bit = p_hi ? (|prod_q[22:0]) : (|prod_q[21:0]);
  assign round_up   = guard_bit & (sticky_bit | frac_t[0]);
  assign frac_inc   = {1'b0, frac_t} + 24'd1;
  // A carry out of the fraction leaves frac_inc[22:0] == 0 and bumps the exponent.
  assign frac_r     = round_up ? frac_inc[22:0] : frac_t;
  assign exp_r      = (round_up && frac_inc[23]) ? (exp_t + 10'sd1) : exp_t;
`else
  // Truncation keeps results bit-identical to the combinational fp unit.
  assign frac_r = frac_t;
  assign exp_r  = exp_t;
`endif

  // ---------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        sign_d = op_sign;
        if (is_special) begin
          result_d = special_res;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          state_d  = S_DONE;
        end else begin
          exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
          mcand_d  = {1'b1, fa};
          mplier_d = {1'b1, fb};
          prod_d   = 48'd0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end

      S_MUL: begin
        prod_d   = prod_step;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (exp_r >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
        end else if (exp_r <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          ovf_d    = 1'b0;
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_r[7:0], frac_r};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      mcand_q  <= 24'd0;
      mplier_q <= 24'd0;
      prod_q   <= 48'd0;
      cnt_q    <= '0;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Iterative IEEE-754 binary32 multiplier with start/done handshake.
- Feeds the result mux alongside the combinational fp add unit in the multicycle datapath.
- The main control FSM pulses start, stalls on busy, and captures result on done.
- Shift-add mantissa multiply over several cycles, to keep the 24x24 array off the critical path.

Parameters:
- BITS_PER_CYCLE, 1: multiplier bits consumed per MUL cycle. Legal values 1, 2, 3, 4, 6, 8, 12. MUL phase lasts 24/BITS_PER_CYCLE cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  32  operand A, binary32.
- b  in  32  operand B, binary32.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; result is valid from this cycle onward.
- result  out  32  product. Held until the next done.
- overflow  out  1  last result saturated to infinity. Updated with result.
- underflow  out  1  last result flushed to zero. Updated with result.

Behaviour:
- Reset (clk edge with reset==0): state IDLE; result=0, done=0, busy=0, overflow=0, underflow=0; all internal registers cleared. Reset mid-operation aborts with no done.
- States: IDLE, UNPACK, MUL, NORM, DONE.
- IDLE→UNPACK on an edge with start=1. a and b are latched at that edge; later input changes are ignored.
- start in any non-IDLE state is ignored.
- UNPACK:
  - sign = a[31]^b[31].
  - 10-bit signed exp = ea + eb - 127.
  - Mantissas = {1, frac}.
  - exp field 0 is treated as zero (denormals flushed).
- UNPACK special cases go straight to DONE:
  - either operand NaN, or inf×zero → 0x7FC00000.
  - else either operand inf → {sign, 0xFF, 0}.
  - else either operand zero → {sign, 31'b0}.
- UNPACK→MUL otherwise, with the 48-bit product register = 0 and the iteration counter = 0.
- MUL: each cycle adds multiplicand × (next BITS_PER_CYCLE multiplier bits), shifted appropriately; counter increments. After 24/BITS_PER_CYCLE cycles → NORM.
- NORM:
  - if product[47]: frac=product[46:24], exp+1; else frac=product[45:23].
  - Truncation rounding (see optional feature).
  - exp ≥ 255 → {sign, 0xFF, 0}, overflow=1.
  - exp ≤ 0 → {sign, 31'b0}, underflow=1.
  - → DONE.
- DONE: result/overflow/underflow registered at entry; done=1 for exactly this cycle; → IDLE. Special-case paths clear both flags.
- Latency, counting the start-sampling edge as edge 1:
  - done visible after edge 3 + 24/BITS_PER_CYCLE (27 for default).
  - special cases: done after edge 2.
- busy is high from edge 1 until the edge leaving DONE.
- Minimum spacing between back-to-back requests: one IDLE cycle after DONE.

Optional Feature:
- Macro FP_MUL_RNE_EN.
- Defined: NORM rounds to nearest-even. guard = bit below frac LSB; sticky = OR of all lower product bits. Round up when guard & (sticky | lsb).
  - Mantissa carry-out on rounding → frac=0, exp+1.
  - Overflow is checked after rounding.
  - Latency unchanged.
- Undefined: truncation, bit-compatible with the combinational fp unit.

Test Plan:
- 2.0 × 3.0 (a=0x40000000, b=0x40400000, start 1 cycle) → result 0x40C00000, done after edge 27, busy high 27 cycles, flags 0.
- 1.5 × 1.5 (0x3FC00000 × 0x3FC00000) → 0x40100000, normalization shift path.
- 0x00000000 × 0x7F800000 → 0x7FC00000 at edge 2.
- 0x80000000 × 0x3F800000 → 0x80000000 at edge 2.
- 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1.
- 0x00800000 × 0x00800000 → 0x00000000, underflow=1.
- 0x3FC00001 × 0x3FC00001 → 0x40100001 without FP_MUL_RNE_EN; 0x40100002 with it.
- Reset mid-operation: start 2.0×3.0; drive start=1 with 0x3F800000×0x3F800000 at edge 10 → ignored, result still 0x40C00000.
  - Then start again and pull reset low at edge 12 → busy=0, done never pulses, result=0.
  - Next request then completes normally.
